// File: rtl/vga_pkg.sv
// Shared timing constants, polarity codes and pipeline stage type
// for the VGA sync generator.
package vga_pkg;

  localparam int SYNC_ACT_LOW  = 0;
  localparam int SYNC_ACT_HIGH = 1;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  function automatic int h_total(
    input int act,
    input int fp,
    input int sw,
    input int bp
  );
    return act + fp + sw + bp;
  endfunction

  function automatic int v_total(
    input int act,
    input int fp,
    input int sw,
    input int bp
  );
    return act + fp + sw + bp;
  endfunction

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic lstart;
    logic fstart;
  } stage_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one display axis; wrap_o marks
// the increment that returns the count to zero.
module vga_axis_counter #(
  parameter int CW = 11
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic [CW-1:0] total_i,
  output logic [CW-1:0] count_o,
  output logic          wrap_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign wrap_o  = inc_i && (cnt_q == total_i - CW'(1));
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync generator on clk_50mhz with pixel clock-enable.
// Define VGA_TIMING_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int HS_POL   = SYNC_ACT_LOW,
  parameter int VS_POL   = SYNC_ACT_LOW,
  parameter int PIPE     = 2,
  parameter int CW       = 11
) (
  input  logic          clk_50mhz,
  input  logic          rst,
  input  logic          en,
  output logic          pix_ce,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]    frame_cnt
`endif
);

  localparam int H_TOTAL =
    h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);
  localparam stage_t IDLE = '{
    hs: ~HS_ACT, vs: ~VS_ACT, blank: 1'b1,
    lstart: 1'b0, fstart: 1'b0
  };

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 ||
      H_BP == 0 || V_ACTIVE == 0 || V_FP == 0 ||
      V_SYNC == 0 || V_BP == 0 ||
      CLK_DIV < 1 || CLK_DIV > 16 ||
      PIPE < 1 || PIPE > 4 ||
      H_TOTAL >= (1 << CW) ||
      V_TOTAL >= (1 << CW)) begin : g_bad_param
    $error("vga_timing_gen: illegal parameter set");
  end

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic          pce_q;
  logic          h_wrap;
  logic          v_wrap;
  stage_t        raw;
  stage_t        pipe_q [PIPE];
  stage_t        last;

  assign pix_ce = en && !rst && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      div_q <= '0;
      pce_q <= 1'b0;
    end else begin
      div_q <= div_d;
      pce_q <= pix_ce;
    end
  end

  vga_axis_counter #(.CW(CW)) u_h (
    .clk_i   (clk_50mhz),
    .rst_i   (rst),
    .inc_i   (pix_ce),
    .total_i (CW'(H_TOTAL)),
    .count_o (h_count),
    .wrap_o  (h_wrap)
  );

  vga_axis_counter #(.CW(CW)) u_v (
    .clk_i   (clk_50mhz),
    .rst_i   (rst),
    .inc_i   (h_wrap),
    .total_i (CW'(V_TOTAL)),
    .count_o (v_count),
    .wrap_o  (v_wrap)
  );

  always_comb begin
    raw = IDLE;
    raw.hs = (h_count >= CW'(HS_BEG) &&
              h_count <  CW'(HS_END)) ? HS_ACT : ~HS_ACT;
    raw.vs = (v_count >= CW'(VS_BEG) &&
              v_count <  CW'(VS_END)) ? VS_ACT : ~VS_ACT;
    raw.blank  = !(h_count < CW'(H_ACTIVE) &&
                   v_count < CW'(V_ACTIVE));
    raw.lstart = (h_count == '0);
    raw.fstart = (h_count == '0) && (v_count == '0);
  end

  // Delay line matches video-memory and character-ROM latency.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) begin
        pipe_q[i] <= IDLE;
      end
    end else if (pix_ce) begin
      pipe_q[0] <= raw;
      for (int i = 1; i < PIPE; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign last        = pipe_q[PIPE-1];
  assign hsync       = last.hs;
  assign vsync       = last.vs;
  assign blank       = last.blank;
  assign line_start  = last.lstart && pce_q && en;
  assign frame_start = last.fstart && pce_q && en;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] fcnt_q;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      fcnt_q <= 8'd0;
    end else if (v_wrap) begin
      fcnt_q <= fcnt_q + 8'd1;
    end
  end

  assign frame_cnt = fcnt_q;
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480@60 sync generator used by the text-mode VGA path.
- Runs directly on clk_50mhz and derives an internal pixel clock-enable, so no divided clock net or toggle flip-flop is needed.
- Counts 0..TOTAL-1 exactly, with no off-by-one extra column or line.
- Provides pipeline-delayed sync and blank signals so they stay aligned with video-memory and character-ROM read latency. Also provides line and frame strobes for the compositor and cursor logic.

Parameters:
- CLK_DIV, 2: clk_50mhz cycles per pixel (1..16).
- H_ACTIVE, 640: visible columns.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: hsync width.
- H_BP, 48: horizontal back porch.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vsync width.
- V_BP, 33: vertical back porch.
- HS_POL, 0: active level of hsync.
- VS_POL, 0: active level of vsync.
- PIPE, 2: output delay in pixel ticks (1..4).
- CW, 11: counter width.

Ports:
- clk_50mhz  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  run enable; 0 freezes timing
- pix_ce  out  1  one-cycle pixel strobe
- h_count  out  CW  current column, undelayed, for address generation
- v_count  out  CW  current line, undelayed
- hsync  out  1  delayed by PIPE ticks
- vsync  out  1  delayed by PIPE ticks
- blank  out  1  1 outside the active area; delayed by PIPE ticks
- line_start  out  1  one-clk strobe when delayed h==0
- frame_start  out  1  one-clk strobe when delayed h==0 and v==0
- frame_cnt  out  8  present only with VGA_TIMING_FRAME_CNT_EN

Behaviour:
- Reset (synchronous, active-high, dominates en):
  - div counter=0, pix_ce=0, h_count=0, v_count=0.
  - hsync=~HS_POL, vsync=~VS_POL, blank=1.
  - line_start=0, frame_start=0.
  - Every pipeline stage is loaded with the idle values (sync inactive, blank=1, strobes 0).
- Pixel clock-enable:
  - div counts 0..CLK_DIV-1 while en=1; pix_ce=1 in the cycle div==CLK_DIV-1.
  - CLK_DIV=1 gives pix_ce=en.
  - After rst is released, the first pix_ce occurs CLK_DIV cycles later.
- Counters (update only on pix_ce):
  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - h increments and wraps H_TOTAL-1 -> 0. On that wrap, v increments and wraps V_TOTAL-1 -> 0.
- Raw decode from the current counters:
  - hs_raw = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL. vs_raw is the same on v.
  - blank_raw = ~(h<H_ACTIVE && v<V_ACTIVE).
- Pipeline:
  - PIPE-deep shift register, advanced only on pix_ce, carrying {hs,vs,blank,h==0,v==0}.
  - hsync, vsync and blank are the last stage and hold between ticks.
  - line_start = last-stage (h==0) AND a registered pix_ce, i.e. high exactly one clk_50mhz cycle, in the cycle after the tick that loaded the stage.
  - frame_start = last-stage (h==0 && v==0) AND the same registered pix_ce; high exactly one cycle under the same rule.
- en=0:
  - div, counters and pipeline all hold; pix_ce=0; strobes=0.
  - Resuming continues from the held state with no skipped pixel.
- Reset mid-frame: all outputs return to reset values on the next edge; no partial sync pulse is extended.
- Parameter legality: elaboration error when any H/V value is 0, when CLK_DIV or PIPE is out of range, or when H_TOTAL or V_TOTAL >= 2^CW.

Optional Feature:
- VGA_TIMING_FRAME_CNT_EN defined:
  - frame_cnt is 8 bits, reset 0.
  - Increments on the pix_ce where the h and v counters both wrap to 0; wraps 255 -> 0.
  - Replaces the separate slow clock divider used for cursor blink.
- Not defined: port and register absent; no other change.

Decomposition:
- Shared package vga_pkg:
  - 640x480@60 default timing constants.
  - Polarity constants SYNC_ACT_LOW=0 and SYNC_ACT_HIGH=1.
  - Localparam functions for H_TOTAL and V_TOTAL.
  - Struct typedef for the pipeline stage {hs,vs,blank,lstart,fstart}.
- One natural sub-module: vga_axis_counter. It is instantiated twice (h and v), takes an increment enable and a total, and outputs count and wrap.

Test Plan:
- Defaults, rst for 3 cycles then en=1:
  - pix_ce every 2nd cycle.
  - h_count reaches 799 then 0; v_count increments on that wrap.
  - Consecutive frame_start strobes are 840000 cycles apart.
- Defaults, PIPE=2:
  - hsync falls 2 pixel ticks after h_count becomes 656 and stays low exactly 192 clk cycles.
  - vsync is low for exactly 2 lines (3200 cycles) starting at line 490.
- Blank: on lines 0..479 blank=0 for exactly 640 ticks per line; blank=1 on all of lines 480..524.
- en deasserted at h=100 for 50 cycles: h_count, hsync and blank hold; pix_ce=0; after re-enable h continues at 101.
- rst pulsed at v=300, h=400: next edge gives h=v=0, hsync=vsync=1, blank=1, strobes 0; first frame_start appears PIPE ticks after restart.
- With VGA_TIMING_FRAME_CNT_EN, CLK_DIV=1 and small parameters (H 4/1/1/1, V 2/1/1/1): frame_cnt wraps 255 -> 0 after 256 frames.
